// File: rtl/au_sequencer_if.sv
// Bundle of the sequencer's command, arithmetic-unit and response signals.
// The sequencer is the slave of the command stream; the environment that issues
// commands, models the arithmetic unit and takes responses uses the master side.
interface au_sequencer_if;
    // Command channel
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;

    // Arithmetic unit channel
    logic [7:0]  au_a;
    logic [7:0]  au_b;
    logic        au_startadd;
    logic        au_startsub;
    logic        au_startmultiplier;
    logic        au_startdiv;
    logic [15:0] au_result;
    logic        au_done;
    logic        au_overflow;
    logic        au_negative;
    logic        au_zero;
    logic        au_carry_out;

    // Response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic [1:0]  rsp_op;
    logic        rsp_timeout;

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b,
        input  au_result, au_done, au_overflow, au_negative, au_zero, au_carry_out,
        input  rsp_ready,
        output cmd_ready,
        output au_a, au_b, au_startadd, au_startsub, au_startmultiplier, au_startdiv,
        output rsp_valid, rsp_result, rsp_flags, rsp_op, rsp_timeout
    );

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b,
        output au_result, au_done, au_overflow, au_negative, au_zero, au_carry_out,
        output rsp_ready,
        input  cmd_ready,
        input  au_a, au_b, au_startadd, au_startsub, au_startmultiplier, au_startdiv,
        input  rsp_valid, rsp_result, rsp_flags, rsp_op, rsp_timeout
    );
endinterface

// File: rtl/au_sequencer.sv
// Sequences one arithmetic operation at a time: accepts a command, holds the
// matching one-hot start level to the arithmetic unit until it answers or a
// timeout expires, idles the starts for one recovery cycle and then presents a
// registered response until it is taken. Every output comes straight from a flop.
module au_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 40
) (
    input  logic          clk,
    input  logic          rst,
    au_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StRecover,
        StResp
    } state_e;

    // Last counter value before the timeout fires; the counter is 6 bits wide.
    localparam logic [5:0] CntLast = 6'(TIMEOUT_CYCLES - 1);

    state_e      r_state;
    state_e      w_state;
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt;
    logic        r_cmd_ready;
    logic        w_cmd_ready;
    logic [7:0]  r_au_a;
    logic [7:0]  w_au_a;
    logic [7:0]  r_au_b;
    logic [7:0]  w_au_b;
    // Start levels, bit order {div, mul, sub, add} so cmd_op indexes directly.
    logic [3:0]  r_start;
    logic [3:0]  w_start;
    logic        r_rsp_valid;
    logic        w_rsp_valid;
    logic [15:0] r_rsp_result;
    logic [15:0] w_rsp_result;
    logic [3:0]  r_rsp_flags;
    logic [3:0]  w_rsp_flags;
    logic [1:0]  r_rsp_op;
    logic [1:0]  w_rsp_op;
    logic        r_rsp_timeout;
    logic        w_rsp_timeout;

    logic        w_accept;
    logic [3:0]  w_flags_cap;

    assign w_accept = bus.cmd_valid && r_cmd_ready;

    // Add/sub report the unit's own flags; mul/div flags are derived from the result.
    assign w_flags_cap = r_rsp_op[1] ?
                         {1'b0, bus.au_result[15], (bus.au_result == 16'd0), 1'b0} :
                         {bus.au_overflow, bus.au_negative, bus.au_zero, bus.au_carry_out};

    // State and output registers; reset drops the start and discards any pending op.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= StIdle;
            r_cnt         <= 6'd0;
            r_cmd_ready   <= 1'b0;
            r_au_a        <= 8'd0;
            r_au_b        <= 8'd0;
            r_start       <= 4'd0;
            r_rsp_valid   <= 1'b0;
            r_rsp_result  <= 16'd0;
            r_rsp_flags   <= 4'd0;
            r_rsp_op      <= 2'd0;
            r_rsp_timeout <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_cnt         <= w_cnt;
            r_cmd_ready   <= w_cmd_ready;
            r_au_a        <= w_au_a;
            r_au_b        <= w_au_b;
            r_start       <= w_start;
            r_rsp_valid   <= w_rsp_valid;
            r_rsp_result  <= w_rsp_result;
            r_rsp_flags   <= w_rsp_flags;
            r_rsp_op      <= w_rsp_op;
            r_rsp_timeout <= w_rsp_timeout;
        end
    end

    // Next-state and next-output decode; every register holds unless a state updates it.
    always_comb begin
        w_state       = r_state;
        w_cnt         = r_cnt;
        w_cmd_ready   = r_cmd_ready;
        w_au_a        = r_au_a;
        w_au_b        = r_au_b;
        w_start       = r_start;
        w_rsp_valid   = r_rsp_valid;
        w_rsp_result  = r_rsp_result;
        w_rsp_flags   = r_rsp_flags;
        w_rsp_op      = r_rsp_op;
        w_rsp_timeout = r_rsp_timeout;

        unique case (r_state)
            StIdle: begin
                w_cmd_ready = 1'b1;
                w_start     = 4'd0;
                w_rsp_valid = 1'b0;
                if (w_accept) begin
                    w_cmd_ready = 1'b0;
                    w_au_a      = bus.cmd_a;
                    w_au_b      = bus.cmd_b;
                    w_start     = 4'b0001 << bus.cmd_op;
                    w_rsp_op    = bus.cmd_op;
                    w_cnt       = 6'd0;
                    w_state     = StIssue;
                end
            end

            StIssue: begin
                w_cmd_ready = 1'b0;
                // A done on the final counted cycle still wins over the timeout.
                if (bus.au_done) begin
                    w_start       = 4'd0;
                    w_rsp_result  = bus.au_result;
                    w_rsp_flags   = w_flags_cap;
                    w_rsp_timeout = 1'b0;
                    w_state       = StRecover;
                end else if (r_cnt == CntLast) begin
                    w_start       = 4'd0;
                    w_rsp_result  = 16'd0;
                    w_rsp_flags   = 4'd0;
                    w_rsp_timeout = 1'b1;
                    w_state       = StRecover;
                end else begin
                    w_cnt = r_cnt + 6'd1;
                end
            end

            StRecover: begin
                w_cmd_ready = 1'b0;
                w_start     = 4'd0;
                w_rsp_valid = 1'b1;
                w_state     = StResp;
            end

            StResp: begin
                w_cmd_ready = 1'b0;
                w_start     = 4'd0;
                if (bus.rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_cmd_ready = 1'b1;
                    w_state     = StIdle;
                end
            end

            default: begin
                w_cmd_ready = 1'b0;
                w_start     = 4'd0;
                w_rsp_valid = 1'b0;
                w_state     = StIdle;
            end
        endcase
    end

    assign bus.cmd_ready          = r_cmd_ready;
    assign bus.au_a               = r_au_a;
    assign bus.au_b               = r_au_b;
    assign bus.au_startadd        = r_start[0];
    assign bus.au_startsub        = r_start[1];
    assign bus.au_startmultiplier = r_start[2];
    assign bus.au_startdiv        = r_start[3];
    assign bus.rsp_valid          = r_rsp_valid;
    assign bus.rsp_result         = r_rsp_result;
    assign bus.rsp_flags          = r_rsp_flags;
    assign bus.rsp_op             = r_rsp_op;
    assign bus.rsp_timeout        = r_rsp_timeout;

endmodule

// File: tb/tb_au_sequencer.sv
// Self-checking bench for au_sequencer: a behavioural arithmetic-unit responder
// with programmable answer delay and stray done pulses, a transaction-level
// reference of the expected response and start timing, directed corner cases
// and a randomized command stream.
module tb_au_sequencer;

    localparam int TO = 40;

    logic clk = 1'b0;
    logic rst = 1'b0;

    au_sequencer_if bus ();

    au_sequencer #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] starts;
    assign starts = {bus.au_startdiv, bus.au_startmultiplier, bus.au_startsub, bus.au_startadd};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Arithmetic unit behaviour: {flags[3:0], result[15:0]}. Mul/div flags are junk.
    function automatic logic [19:0] au_compute(input logic [1:0] op, input logic [7:0] a,
                                               input logic [7:0] b, input logic [3:0] junk);
        logic [8:0]  s;
        logic [15:0] r;
        logic [3:0]  f;
        s = 9'd0;
        r = 16'd0;
        f = junk;
        case (op)
            2'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = {{8{s[7]}}, s[7:0]};
                f = {(a[7] == b[7]) && (s[7] != a[7]), s[7], s[7:0] == 8'd0, s[8]};
            end
            2'd1: begin
                s = {1'b0, a} - {1'b0, b};
                r = {{8{s[7]}}, s[7:0]};
                f = {(a[7] != b[7]) && (s[7] != a[7]), s[7], s[7:0] == 8'd0, s[8]};
            end
            2'd2: r = 16'(a) * 16'(b);
            default: r = (b == 8'd0) ? 16'hFFFF : {a / b, a % b};
        endcase
        return {f, r};
    endfunction

    // Arithmetic unit model: answers after au_delay+1 sampled start cycles.
    int au_delay    = 1;
    bit au_spurious = 1'b0;
    int au_cnt      = 0;

    initial begin
        logic [1:0]  op;
        logic [19:0] fr;
        bus.au_done      = 1'b0;
        bus.au_result    = 16'd0;
        bus.au_overflow  = 1'b0;
        bus.au_negative  = 1'b0;
        bus.au_zero      = 1'b0;
        bus.au_carry_out = 1'b0;
        forever begin
            @(negedge clk);
            bus.au_done = 1'b0;
            if (starts != 4'd0) begin
                check_eq("start_onehot", 32'($countones(starts)), 32'd1);
                au_cnt++;
                if (au_cnt == au_delay + 1) begin
                    op = starts[0] ? 2'd0 : starts[1] ? 2'd1 : starts[2] ? 2'd2 : 2'd3;
                    fr = au_compute(op, bus.au_a, bus.au_b, 4'($urandom));
                    bus.au_result = fr[15:0];
                    {bus.au_overflow, bus.au_negative, bus.au_zero, bus.au_carry_out} = fr[19:16];
                    bus.au_done = 1'b1;
                end
            end else begin
                au_cnt = 0;
                if (au_spurious && $urandom_range(0, 3) == 0) begin
                    bus.au_result = 16'($urandom);
                    {bus.au_overflow, bus.au_negative, bus.au_zero, bus.au_carry_out} =
                        4'($urandom);
                    bus.au_done = 1'b1;
                end
            end
        end
    end

    // One command through to its response handshake, checked against the reference.
    task automatic run_txn(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                           input int d, input int hold, input bit keep_valid);
        logic [19:0] fr;
        logic [15:0] exp_res;
        logic [3:0]  exp_flags;
        logic        exp_to;
        int          exp_start;
        int          start_cycles;
        int          n;
        au_delay = d;
        if (d <= TO - 1) begin
            fr        = au_compute(op, a, b, 4'd0);
            exp_res   = fr[15:0];
            exp_flags = op[1] ? {1'b0, exp_res[15], exp_res == 16'd0, 1'b0} : fr[19:16];
            exp_to    = 1'b0;
            exp_start = d + 1;
        end else begin
            exp_res   = 16'd0;
            exp_flags = 4'd0;
            exp_to    = 1'b1;
            exp_start = TO;
        end

        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        n = 0;
        while (!bus.cmd_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            check_eq("cmd_accept", 32'(bus.cmd_ready), 32'd1);
            bus.cmd_valid = 1'b0;
            return;
        end
        @(negedge clk);
        if (keep_valid) begin
            bus.cmd_op = ~op;
            bus.cmd_a  = ~a;
            bus.cmd_b  = ~b;
        end else begin
            bus.cmd_valid = 1'b0;
        end

        start_cycles = 0;
        n = 0;
        while (starts != 4'd0 && n < 100) begin
            check_eq("issue_au_a", 32'(bus.au_a), 32'(a));
            check_eq("issue_au_b", 32'(bus.au_b), 32'(b));
            check_eq("issue_start_sel", 32'(starts), 32'(4'b0001 << op));
            check_eq("issue_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            start_cycles++;
            n++;
            @(negedge clk);
        end
        check_eq("start_cycles", 32'(start_cycles), 32'(exp_start));
        check_eq("recover_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("recover_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);

        for (int i = 0; i <= hold; i++) begin
            check_eq("rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check_eq("rsp_result", 32'(bus.rsp_result), 32'(exp_res));
            check_eq("rsp_flags", 32'(bus.rsp_flags), 32'(exp_flags));
            check_eq("rsp_op", 32'(bus.rsp_op), 32'(op));
            check_eq("rsp_timeout", 32'(bus.rsp_timeout), 32'(exp_to));
            check_eq("resp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check_eq("resp_au_a_kept", 32'(bus.au_a), 32'(a));
            if (i == hold) bus.rsp_ready = 1'b1;
            @(negedge clk);
        end
        bus.rsp_ready = 1'b0;
        bus.cmd_valid = 1'b0;
        check_eq("post_hs_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("post_hs_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_a     = 8'd0;
        bus.cmd_b     = 8'd0;
        bus.rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("rst_starts", 32'(starts), 32'd0);
        check_eq("rst_au_a", 32'(bus.au_a), 32'd0);
        check_eq("rst_au_b", 32'(bus.au_b), 32'd0);
        check_eq("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
        check_eq("rst_rsp_flags", 32'(bus.rsp_flags), 32'd0);
        check_eq("rst_rsp_op", 32'(bus.rsp_op), 32'd0);
        check_eq("rst_rsp_timeout", 32'(bus.rsp_timeout), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rel_cmd_ready", 32'(bus.cmd_ready), 32'd1);

        // Directed operations with a first-edge answer.
        run_txn(2'd0, 8'h30, 8'h12, 1, 0, 1'b0);
        run_txn(2'd0, 8'h7F, 8'h01, 1, 0, 1'b0);
        run_txn(2'd1, 8'h80, 8'h80, 1, 0, 1'b0);
        run_txn(2'd2, 8'hF0, 8'h10, 1, 0, 1'b0);
        run_txn(2'd3, 8'h43, 8'h08, 5, 0, 1'b0);
        // Timeout boundary: answer on the last allowed cycle, one late, never.
        run_txn(2'd0, 8'h11, 8'h22, TO - 1, 0, 1'b0);
        run_txn(2'd1, 8'h05, 8'h09, TO, 0, 1'b0);
        run_txn(2'd0, 8'h01, 8'h02, 1000, 0, 1'b0);
        // Backpressure with a competing command held valid throughout.
        au_spurious = 1'b1;
        run_txn(2'd2, 8'h0C, 8'h0D, 2, 10, 1'b1);

        // Reset while a multiply is in flight.
        au_delay = 1000;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd2;
        bus.cmd_a     = 8'h21;
        bus.cmd_b     = 8'h03;
        n = 0;
        while (!bus.cmd_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("mid_mul_start", 32'(bus.au_startmultiplier), 32'd1);
        #2 rst = 1'b0;
        #1;
        check_eq("async_mul_drop", 32'(bus.au_startmultiplier), 32'd0);
        check_eq("async_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_eq("async_au_a", 32'(bus.au_a), 32'd0);
        check_eq("async_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
            check_eq("post_rst_no_start", 32'(starts), 32'd0);
        end
        run_txn(2'd3, 8'h40, 8'h08, 1, 0, 1'b0);

        // Randomized stream, including delays around the timeout boundary.
        for (int t = 0; t < 60; t++) begin
            int d;
            au_spurious = 1'($urandom);
            d = ($urandom_range(0, 4) == 0) ? $urandom_range(TO - 3, TO + 3)
                                            : $urandom_range(1, 8);
            run_txn(2'($urandom), 8'($urandom), 8'($urandom), d,
                    $urandom_range(0, 4), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
